// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle control unit (states,
// opcodes, FUNCT codes, ALU operations and datapath mux selects).
package ctrl_pkg;

  typedef enum logic [4:0] {
    ST_RST     = 5'd0,
    ST_FETCH   = 5'd1,
    ST_DECODE  = 5'd2,
    ST_EXEC_R  = 5'd3,
    ST_WB_R    = 5'd4,
    ST_EXEC_I  = 5'd5,
    ST_WB_I    = 5'd6,
    ST_ADDR    = 5'd7,
    ST_MEM_ADR = 5'd8,
    ST_MEM_RD  = 5'd9,
    ST_MEM_WB  = 5'd10,
    ST_MEM_WR  = 5'd11,
    ST_BRANCH  = 5'd12,
    ST_JUMP    = 5'd13,
    ST_OVF     = 5'd14
  } state_e;

  // Instruction opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type FUNCT codes, instruction bits [5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;

  // ALU operation codes
  localparam logic [2:0] ULA_PASSA = 3'b000;
  localparam logic [2:0] ULA_ADD   = 3'b001;
  localparam logic [2:0] ULA_SUB   = 3'b010;
  localparam logic [2:0] ULA_AND   = 3'b011;
  localparam logic [2:0] ULA_XOR   = 3'b110;
  localparam logic [2:0] ULA_CMP   = 3'b111;

  // Register destination select
  localparam logic [1:0] WREG_RT = 2'b00;
  localparam logic [1:0] WREG_RD = 2'b01;
  localparam logic [1:0] WREG_RA = 2'b10;

  // Register write data, memory address and ALU A selects
  localparam logic WDATA_ALUOUT = 1'b0;
  localparam logic WDATA_MDR    = 1'b1;
  localparam logic IORD_PC      = 1'b0;
  localparam logic IORD_ALUOUT  = 1'b1;
  localparam logic ULAA_PC      = 1'b0;
  localparam logic ULAA_REGA    = 1'b1;

  // ALU B select
  localparam logic [1:0] ULAB_REGB    = 2'b00;
  localparam logic [1:0] ULAB_FOUR    = 2'b01;
  localparam logic [1:0] ULAB_IMM     = 2'b10;
  localparam logic [1:0] ULAB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  // True for the R-type FUNCT codes this control unit executes
  function automatic logic funct_valid(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) ||
           (funct == FN_AND) || (funct == FN_XOR);
  endfunction

  // ALU operation for an R-type FUNCT; unsupported codes map to pass-A
  function automatic logic [2:0] funct_to_ula(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ULA_ADD;
      FN_SUB:  return ULA_SUB;
      FN_AND:  return ULA_AND;
      FN_XOR:  return ULA_XOR;
      default: return ULA_PASSA;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// ctrl_wait_cnt: 4-bit up counter that reloads zero on clr and flags when
// it has reached the programmed last value. Shared by the reset pulse,
// instruction fetch and memory read waits.
module ctrl_wait_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [3:0] last,
  output logic       done
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Next count: reload on clear, otherwise count up and hold at 15
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (count_q != 4'hF) begin
      count_d = count_q + 4'd1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == last);

endmodule

// File: rtl/ctrl_unit_mc.sv
// ctrl_unit_mc: multicycle control FSM for the CPU datapath.
// Build macro CTRL_OVF_EXC_EN adds the EPC_w output and an overflow trap
// for add/sub/addi that redirects the PC to the exception vector (M_PC=11).
module ctrl_unit_mc
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = 1,
  parameter int unsigned RST_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Of,
  input  logic       Ng,
  input  logic       Zr,
  input  logic       Eq,
  input  logic       Gt,
  input  logic       Lt,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  output logic       PC_w,
  output logic       MEM_w,
  output logic       IR_w,
  output logic       RB_w,
  output logic       AB_w,
  output logic       ALUOUT_w,
  output logic       MDR_w,
  output logic [2:0] ULA_C,
  output logic [1:0] M_WREG,
  output logic       M_WDATA,
  output logic       M_IORD,
  output logic       M_ULAA,
  output logic [1:0] M_ULAB,
  output logic [1:0] M_PC,
  output logic       rst_out,
`ifdef CTRL_OVF_EXC_EN
  output logic       EPC_w,
`endif
  output logic [4:0] state_dbg
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_WAIT);
  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] cnt_last;
  logic       cnt_done;
  logic       cnt_clr;

  // ALU status flags this control unit never consults
`ifdef CTRL_OVF_EXC_EN
  logic unused_flags;
  assign unused_flags = ^{Ng, Zr, Gt, Lt};
`else
  logic unused_flags;
  assign unused_flags = ^{Of, Ng, Zr, Gt, Lt};
`endif

  // The wait counter restarts from zero whenever the FSM enters a new state
  assign cnt_clr = (state_d != state_q);

  ctrl_wait_cnt u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .last  (cnt_last),
    .done  (cnt_done)
  );

  // Next-state and Moore output decode
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_last = 4'd0;
    PC_w     = 1'b0;
    MEM_w    = 1'b0;
    IR_w     = 1'b0;
    RB_w     = 1'b0;
    AB_w     = 1'b0;
    ALUOUT_w = 1'b0;
    MDR_w    = 1'b0;
    ULA_C    = ULA_PASSA;
    M_WREG   = WREG_RT;
    M_WDATA  = WDATA_ALUOUT;
    M_IORD   = IORD_PC;
    M_ULAA   = ULAA_PC;
    M_ULAB   = ULAB_REGB;
    M_PC     = PCSRC_ALU;
    rst_out  = 1'b0;
`ifdef CTRL_OVF_EXC_EN
    EPC_w    = 1'b0;
`endif

    case (state_q)
      ST_RST: begin
        rst_out  = 1'b1;
        cnt_last = RST_LAST;
        if (cnt_done) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        M_IORD   = IORD_PC;
        M_ULAA   = ULAA_PC;
        M_ULAB   = ULAB_FOUR;
        ULA_C    = ULA_ADD;
        cnt_last = MEM_LAST;
        if (cnt_done) begin
          IR_w    = 1'b1;
          PC_w    = 1'b1;
          M_PC    = PCSRC_ALU;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // Precompute the branch target into ALUOut while registers load
        AB_w     = 1'b1;
        ALUOUT_w = 1'b1;
        M_ULAA   = ULAA_PC;
        M_ULAB   = ULAB_IMM_SH2;
        ULA_C    = ULA_ADD;
        case (OPCODE)
          OP_RTYPE:     state_d = ST_EXEC_R;
          OP_ADDI:      state_d = ST_EXEC_I;
          OP_LW, OP_SW: state_d = ST_ADDR;
          OP_BEQ,
          OP_BNE:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FETCH;  // unknown opcode runs as a NOP
        endcase
      end

      ST_EXEC_R: begin
        M_ULAA   = ULAA_REGA;
        M_ULAB   = ULAB_REGB;
        ALUOUT_w = 1'b1;
        ULA_C    = funct_to_ula(FUNCT);
        if (!funct_valid(FUNCT)) begin
          state_d = ST_FETCH;
`ifdef CTRL_OVF_EXC_EN
        end else if (Of && ((FUNCT == FN_ADD) || (FUNCT == FN_SUB))) begin
          state_d = ST_OVF;
`endif
        end else begin
          state_d = ST_WB_R;
        end
      end

      ST_WB_R: begin
        RB_w    = 1'b1;
        M_WREG  = WREG_RD;
        M_WDATA = WDATA_ALUOUT;
        state_d = ST_FETCH;
      end

      ST_EXEC_I: begin
        M_ULAA   = ULAA_REGA;
        M_ULAB   = ULAB_IMM;
        ULA_C    = ULA_ADD;
        ALUOUT_w = 1'b1;
`ifdef CTRL_OVF_EXC_EN
        state_d  = Of ? ST_OVF : ST_WB_I;
`else
        state_d  = ST_WB_I;
`endif
      end

      ST_WB_I: begin
        RB_w    = 1'b1;
        M_WREG  = WREG_RT;
        M_WDATA = WDATA_ALUOUT;
        state_d = ST_FETCH;
      end

      ST_ADDR: begin
        M_ULAA   = ULAA_REGA;
        M_ULAB   = ULAB_IMM;
        ULA_C    = ULA_ADD;
        ALUOUT_w = 1'b1;
        state_d  = ST_MEM_ADR;
      end

      ST_MEM_ADR: begin
        // Address setup: ALUOut drives the memory address one cycle before
        // the memory samples it for either a read or a write.
        M_IORD  = IORD_ALUOUT;
        state_d = (OPCODE == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end

      ST_MEM_RD: begin
        M_IORD   = IORD_ALUOUT;
        cnt_last = MEM_LAST;
        if (cnt_done) begin
          MDR_w   = 1'b1;
          state_d = ST_MEM_WB;
        end
      end

      ST_MEM_WB: begin
        RB_w    = 1'b1;
        M_WREG  = WREG_RT;
        M_WDATA = WDATA_MDR;
        state_d = ST_FETCH;
      end

      ST_MEM_WR: begin
        M_IORD  = IORD_ALUOUT;
        MEM_w   = 1'b1;
        state_d = ST_FETCH;
      end

      ST_BRANCH: begin
        M_ULAA  = ULAA_REGA;
        M_ULAB  = ULAB_REGB;
        ULA_C   = ULA_CMP;
        M_PC    = PCSRC_ALUOUT;
        PC_w    = (OPCODE == OP_BEQ) ? Eq : ~Eq;
        state_d = ST_FETCH;
      end

      ST_JUMP: begin
        M_PC    = PCSRC_JUMP;
        PC_w    = 1'b1;
        state_d = ST_FETCH;
      end

`ifdef CTRL_OVF_EXC_EN
      ST_OVF: begin
        EPC_w   = 1'b1;
        PC_w    = 1'b1;
        M_PC    = PCSRC_EXC;
        state_d = ST_FETCH;
      end
`endif

      default: state_d = ST_RST;
    endcase

    // Reset is synchronous, so the state still decodes normally in the
    // cycle it is raised; suppress every write so nothing leaks at that edge.
    if (reset) begin
      PC_w     = 1'b0;
      MEM_w    = 1'b0;
      IR_w     = 1'b0;
      RB_w     = 1'b0;
      AB_w     = 1'b0;
      ALUOUT_w = 1'b0;
      MDR_w    = 1'b0;
`ifdef CTRL_OVF_EXC_EN
      EPC_w    = 1'b0;
`endif
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values regardless of process ordering.
    if (reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// tb_ctrl_unit_mc: directed bench for ctrl_unit_mc. Instance A uses
// MEM_WAIT=2/RST_CYCLES=2, instance B uses MEM_WAIT=0/RST_CYCLES=1.
// Build with CTRL_OVF_EXC_EN defined to cover the overflow trap.
module tb_ctrl_unit_mc;
  import ctrl_pkg::*;

  typedef struct packed {
    logic       pc_w, mem_w, ir_w, rb_w, ab_w, aluout_w, mdr_w, epc_w;
    logic [2:0] ula_c;
    logic [1:0] m_wreg;
    logic       m_wdata, m_iord, m_ulaa;
    logic [1:0] m_ulab, m_pc;
    logic       rst_out;
    logic [4:0] state;
  } obs_t;

  typedef enum int {S_PC, S_MEM, S_IR, S_RB, S_MDR, S_EPC, S_PC11} sig_e;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       of_i = 1'b0, ng_i = 1'b0, zr_i = 1'b0;
  logic       eq_i = 1'b0, gt_i = 1'b0, lt_i = 1'b0;
  logic [5:0] opcode = 6'h00, funct = 6'h00;

  logic       a_pc_w, a_mem_w, a_ir_w, a_rb_w, a_ab_w, a_aluout_w, a_mdr_w;
  logic [2:0] a_ula_c;
  logic [1:0] a_m_wreg, a_m_ulab, a_m_pc;
  logic       a_m_wdata, a_m_iord, a_m_ulaa, a_rst_out;
  logic [4:0] a_state;
  logic       b_pc_w, b_mem_w, b_ir_w, b_rb_w, b_ab_w, b_aluout_w, b_mdr_w;
  logic [2:0] b_ula_c;
  logic [1:0] b_m_wreg, b_m_ulab, b_m_pc;
  logic       b_m_wdata, b_m_iord, b_m_ulaa, b_rst_out;
  logic [4:0] b_state;
`ifdef CTRL_OVF_EXC_EN
  logic       a_epc_w, b_epc_w;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  obs_t tr[$];

  always #5 clk = ~clk;

  ctrl_unit_mc #(.MEM_WAIT(2), .RST_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .Of(of_i), .Ng(ng_i), .Zr(zr_i), .Eq(eq_i),
    .Gt(gt_i), .Lt(lt_i), .OPCODE(opcode), .FUNCT(funct),
    .PC_w(a_pc_w), .MEM_w(a_mem_w), .IR_w(a_ir_w), .RB_w(a_rb_w), .AB_w(a_ab_w),
    .ALUOUT_w(a_aluout_w), .MDR_w(a_mdr_w), .ULA_C(a_ula_c), .M_WREG(a_m_wreg),
    .M_WDATA(a_m_wdata), .M_IORD(a_m_iord), .M_ULAA(a_m_ulaa), .M_ULAB(a_m_ulab),
    .M_PC(a_m_pc), .rst_out(a_rst_out),
`ifdef CTRL_OVF_EXC_EN
    .EPC_w(a_epc_w),
`endif
    .state_dbg(a_state)
  );

  ctrl_unit_mc #(.MEM_WAIT(0), .RST_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .Of(of_i), .Ng(ng_i), .Zr(zr_i), .Eq(eq_i),
    .Gt(gt_i), .Lt(lt_i), .OPCODE(opcode), .FUNCT(funct),
    .PC_w(b_pc_w), .MEM_w(b_mem_w), .IR_w(b_ir_w), .RB_w(b_rb_w), .AB_w(b_ab_w),
    .ALUOUT_w(b_aluout_w), .MDR_w(b_mdr_w), .ULA_C(b_ula_c), .M_WREG(b_m_wreg),
    .M_WDATA(b_m_wdata), .M_IORD(b_m_iord), .M_ULAA(b_m_ulaa), .M_ULAB(b_m_ulab),
    .M_PC(b_m_pc), .rst_out(b_rst_out),
`ifdef CTRL_OVF_EXC_EN
    .EPC_w(b_epc_w),
`endif
    .state_dbg(b_state)
  );

  // Snapshot of one instance's outputs (sel 0 = A, 1 = B)
  function automatic obs_t get_obs(input int sel);
    obs_t o;
    o = '0;
    if (sel == 0) begin
      o.pc_w = a_pc_w; o.mem_w = a_mem_w; o.ir_w = a_ir_w; o.rb_w = a_rb_w;
      o.ab_w = a_ab_w; o.aluout_w = a_aluout_w; o.mdr_w = a_mdr_w;
      o.ula_c = a_ula_c; o.m_wreg = a_m_wreg; o.m_wdata = a_m_wdata;
      o.m_iord = a_m_iord; o.m_ulaa = a_m_ulaa; o.m_ulab = a_m_ulab;
      o.m_pc = a_m_pc; o.rst_out = a_rst_out; o.state = a_state;
`ifdef CTRL_OVF_EXC_EN
      o.epc_w = a_epc_w;
`endif
    end else begin
      o.pc_w = b_pc_w; o.mem_w = b_mem_w; o.ir_w = b_ir_w; o.rb_w = b_rb_w;
      o.ab_w = b_ab_w; o.aluout_w = b_aluout_w; o.mdr_w = b_mdr_w;
      o.ula_c = b_ula_c; o.m_wreg = b_m_wreg; o.m_wdata = b_m_wdata;
      o.m_iord = b_m_iord; o.m_ulaa = b_m_ulaa; o.m_ulab = b_m_ulab;
      o.m_pc = b_m_pc; o.rst_out = b_rst_out; o.state = b_state;
`ifdef CTRL_OVF_EXC_EN
      o.epc_w = b_epc_w;
`endif
    end
    return o;
  endfunction

  function automatic logic [7:0] we_bits(input obs_t o);
    return {o.pc_w, o.mem_w, o.ir_w, o.rb_w, o.ab_w, o.aluout_w, o.mdr_w, o.epc_w};
  endfunction

  function automatic obs_t at(input int i);
    obs_t o;
    o = '0;
    if (i < tr.size()) o = tr[i];
    return o;
  endfunction

  function automatic logic hit(input obs_t o, input sig_e s);
    case (s)
      S_PC:    return o.pc_w;
      S_MEM:   return o.mem_w;
      S_IR:    return o.ir_w;
      S_RB:    return o.rb_w;
      S_MDR:   return o.mdr_w;
      S_EPC:   return o.epc_w;
      default: return o.m_pc == 2'b11;
    endcase
  endfunction

  function automatic int first_hit(input sig_e s);
    for (int i = 0; i < tr.size(); i++) if (hit(tr[i], s) === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_hit(input sig_e s);
    int n = 0;
    for (int i = 0; i < tr.size(); i++) if (hit(tr[i], s) === 1'b1) n++;
    return n;
  endfunction

  // Run one instruction from FETCH entry up to the next FETCH entry,
  // recording one snapshot per cycle into tr.
  task automatic run_instr(input int sel, input logic [5:0] op, input logic [5:0] fn,
                           input logic eq, input logic of);
    obs_t       o;
    logic [4:0] prev;
    bit         done = 0;
    opcode = op; funct = fn; eq_i = eq; of_i = of;
    #1;
    tr.delete();
    o = get_obs(sel);
    vectors++;
    if (o.state !== ST_FETCH) begin
      miscompares++;
      $display("FAIL start_state op=%h: got %0d want %0d", op, o.state, ST_FETCH);
    end
    for (int i = 0; i < 40 && !done; i++) begin
      prev = o.state;
      tr.push_back(o);
      @(posedge clk); #1;
      o = get_obs(sel);
      if (o.state == ST_FETCH && prev != ST_FETCH) done = 1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL instr_timeout op=%h: got no return to FETCH want return within 40 cycles", op);
    end
  endtask

  task automatic reset_and_wait(input int sel);
    bit   seen = 0;
    obs_t o;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      o = get_obs(sel);
      if (o.state == ST_FETCH) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_to_fetch sel=%0d: got state %0d want %0d", sel, o.state, ST_FETCH);
    end
  endtask

  // Reset held 3 edges on A (RST_CYCLES=2): RST, rst_out=1, no writes; the
  // cycle after the last reset edge plus one more keep rst_out high.
  task automatic test_reset();
    obs_t o;
    int   rst_hi;
    reset = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      o = get_obs(0);
      vectors++;
      if (o.state !== ST_RST || o.rst_out !== 1'b1 || we_bits(o) !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_hold edge%0d: got state=%0d rst_out=%b we=%b want state=0 rst_out=1 we=0",
                 e, o.state, o.rst_out, we_bits(o));
      end
    end
    reset = 1'b0;
    rst_hi = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      o = get_obs(0);
      if (o.rst_out !== 1'b1) break;
      rst_hi++;
      vectors++;
      if (we_bits(o) !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_we: got %b want 00000000", we_bits(o));
      end
    end
    vectors++;
    if (rst_hi !== 2) begin
      miscompares++;
      $display("FAIL rst_out_len: got %0d want 2", rst_hi);
    end
    vectors++;
    if (o.state !== ST_FETCH) begin
      miscompares++;
      $display("FAIL post_reset_state: got %0d want %0d", o.state, ST_FETCH);
    end
  endtask

  // add on A (MEM_WAIT=2): fetch 3 cycles, IR_w/PC_w on cycle 3, RB_w on 6
  task automatic test_add();
    run_instr(0, OP_RTYPE, FN_ADD, 1'b0, 1'b0);
    vectors++;
    if (tr.size() !== 6) begin miscompares++; $display("FAIL add_len: got %0d want 6", tr.size()); end
    vectors++;
    if (first_hit(S_IR) !== 2 || count_hit(S_IR) !== 1) begin
      miscompares++;
      $display("FAIL add_ir_w: got idx %0d cnt %0d want idx 2 cnt 1", first_hit(S_IR), count_hit(S_IR));
    end
    vectors++;
    if (first_hit(S_PC) !== 2 || at(2).m_pc !== 2'b00 || at(0).m_ulab !== 2'b01 || at(0).ula_c !== 3'b001) begin
      miscompares++;
      $display("FAIL add_fetch: got pc_idx %0d m_pc %b ulab %b ula %b want 2 00 01 001",
               first_hit(S_PC), at(2).m_pc, at(0).m_ulab, at(0).ula_c);
    end
    vectors++;
    if (at(3).ab_w !== 1'b1 || at(3).aluout_w !== 1'b1 || at(3).m_ulab !== 2'b11) begin
      miscompares++;
      $display("FAIL add_decode: got ab %b aluout %b ulab %b want 1 1 11", at(3).ab_w, at(3).aluout_w, at(3).m_ulab);
    end
    vectors++;
    if (at(4).ula_c !== 3'b001 || at(4).m_ulaa !== 1'b1 || at(4).m_ulab !== 2'b00) begin
      miscompares++;
      $display("FAIL add_exec: got ula %b ulaa %b ulab %b want 001 1 00", at(4).ula_c, at(4).m_ulaa, at(4).m_ulab);
    end
    vectors++;
    if (first_hit(S_RB) !== 5 || at(5).m_wreg !== 2'b01 || at(5).m_wdata !== 1'b0) begin
      miscompares++;
      $display("FAIL add_wb: got rb_idx %0d wreg %b wdata %b want 5 01 0", first_hit(S_RB), at(5).m_wreg, at(5).m_wdata);
    end
  endtask

  // Remaining FUNCT codes plus one unsupported code (slt, 0x2A)
  task automatic test_rtype();
    logic [5:0] fns[4]  = '{6'h22, 6'h24, 6'h26, 6'h2A};
    logic [2:0] ulas[4] = '{3'b010, 3'b011, 3'b110, 3'b000};
    int         lens[4] = '{6, 6, 6, 5};
    int         rbs[4]  = '{1, 1, 1, 0};
    for (int k = 0; k < 4; k++) begin
      run_instr(0, OP_RTYPE, fns[k], 1'b0, 1'b0);
      vectors++;
      if (tr.size() !== lens[k] || at(4).ula_c !== ulas[k] || count_hit(S_RB) !== rbs[k]) begin
        miscompares++;
        $display("FAIL rtype fn=%h: got len %0d ula %b rb %0d want len %0d ula %b rb %0d",
                 fns[k], tr.size(), at(4).ula_c, count_hit(S_RB), lens[k], ulas[k], rbs[k]);
      end
    end
  endtask

  // addi and add with Of: writeback without the trap, OVF with it
  task automatic test_overflow();
    run_instr(0, OP_ADDI, 6'h00, 1'b0, 1'b0);
    vectors++;
    if (tr.size() !== 6 || at(4).m_ulab !== 2'b10 || first_hit(S_RB) !== 5 || at(5).m_wreg !== 2'b00) begin
      miscompares++;
      $display("FAIL addi: got len %0d ulab %b rb_idx %0d wreg %b want 6 10 5 00",
               tr.size(), at(4).m_ulab, first_hit(S_RB), at(5).m_wreg);
    end
    run_instr(0, OP_ADDI, 6'h00, 1'b0, 1'b1);
`ifdef CTRL_OVF_EXC_EN
    vectors++;
    if (tr.size() !== 6 || first_hit(S_EPC) !== 5 || at(5).pc_w !== 1'b1 || at(5).m_pc !== 2'b11 || count_hit(S_RB) !== 0) begin
      miscompares++;
      $display("FAIL addi_ovf: got len %0d epc_idx %0d pc_w %b m_pc %b rb %0d want 6 5 1 11 0",
               tr.size(), first_hit(S_EPC), at(5).pc_w, at(5).m_pc, count_hit(S_RB));
    end
    run_instr(0, OP_RTYPE, FN_SUB, 1'b0, 1'b1);
    vectors++;
    if (first_hit(S_EPC) !== 5 || count_hit(S_RB) !== 0) begin
      miscompares++;
      $display("FAIL sub_ovf: got epc_idx %0d rb %0d want 5 0", first_hit(S_EPC), count_hit(S_RB));
    end
`else
    vectors++;
    if (tr.size() !== 6 || first_hit(S_RB) !== 5 || count_hit(S_PC11) !== 0) begin
      miscompares++;
      $display("FAIL addi_of_ignored: got len %0d rb_idx %0d m_pc11 %0d want 6 5 0",
               tr.size(), first_hit(S_RB), count_hit(S_PC11));
    end
`endif
  endtask

  // beq/bne truth table, jump and an unknown opcode on A (3+M = 5 cycles)
  task automatic test_branch_jump();
    logic [5:0] ops[4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    logic       eqs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       tks[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      run_instr(0, ops[k], 6'h00, eqs[k], 1'b0);
      vectors++;
      if (tr.size() !== 5 || at(4).pc_w !== tks[k] || at(4).m_pc !== 2'b01 || at(4).ula_c !== 3'b111) begin
        miscompares++;
        $display("FAIL branch op=%h eq=%b: got len %0d pc_w %b m_pc %b ula %b want 5 %b 01 111",
                 ops[k], eqs[k], tr.size(), at(4).pc_w, at(4).m_pc, at(4).ula_c, tks[k]);
      end
    end
    run_instr(0, OP_J, 6'h00, 1'b0, 1'b0);
    vectors++;
    if (tr.size() !== 5 || at(4).pc_w !== 1'b1 || at(4).m_pc !== 2'b10) begin
      miscompares++;
      $display("FAIL jump: got len %0d pc_w %b m_pc %b want 5 1 10", tr.size(), at(4).pc_w, at(4).m_pc);
    end
    run_instr(0, 6'h3F, 6'h00, 1'b0, 1'b0);
    vectors++;
    if (tr.size() !== 4 || at(3).state !== ST_DECODE ||
        count_hit(S_RB) + count_hit(S_MEM) + count_hit(S_MDR) !== 0) begin
      miscompares++;
      $display("FAIL bad_opcode: got len %0d state3 %0d writes %0d want 4 %0d 0",
               tr.size(), at(3).state, count_hit(S_RB) + count_hit(S_MEM) + count_hit(S_MDR), ST_DECODE);
    end
  endtask

  // lw/sw on B (MEM_WAIT=0: 6 and 5 cycles) and on A (MEM_WAIT=2: 10 and 7)
  task automatic test_load_store();
    reset_and_wait(1);
    run_instr(1, OP_LW, 6'h00, 1'b0, 1'b0);
    vectors++;
    if (tr.size() !== 6 || first_hit(S_MDR) !== 4 || count_hit(S_MDR) !== 1 || at(4).m_iord !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_m0_read: got len %0d mdr_idx %0d mdr_cnt %0d iord %b want 6 4 1 1",
               tr.size(), first_hit(S_MDR), count_hit(S_MDR), at(4).m_iord);
    end
    vectors++;
    if (first_hit(S_RB) !== 5 || at(5).m_wdata !== 1'b1 || at(5).m_wreg !== 2'b00) begin
      miscompares++;
      $display("FAIL lw_m0_wb: got rb_idx %0d wdata %b wreg %b want 5 1 00", first_hit(S_RB), at(5).m_wdata, at(5).m_wreg);
    end
    run_instr(1, OP_SW, 6'h00, 1'b0, 1'b0);
    vectors++;
    if (tr.size() !== 5 || count_hit(S_MEM) !== 1 || first_hit(S_MEM) !== 4 || at(4).m_iord !== 1'b1 || count_hit(S_RB) !== 0) begin
      miscompares++;
      $display("FAIL sw_m0: got len %0d mem_cnt %0d mem_idx %0d iord %b rb %0d want 5 1 4 1 0",
               tr.size(), count_hit(S_MEM), first_hit(S_MEM), at(4).m_iord, count_hit(S_RB));
    end
    reset_and_wait(0);
    run_instr(0, OP_LW, 6'h00, 1'b0, 1'b0);
    vectors++;
    if (tr.size() !== 10 || first_hit(S_MDR) !== 8 || first_hit(S_RB) !== 9) begin
      miscompares++;
      $display("FAIL lw_m2: got len %0d mdr_idx %0d rb_idx %0d want 10 8 9", tr.size(), first_hit(S_MDR), first_hit(S_RB));
    end
    run_instr(0, OP_SW, 6'h00, 1'b0, 1'b0);
    vectors++;
    if (tr.size() !== 7 || first_hit(S_MEM) !== 6 || count_hit(S_MEM) !== 1) begin
      miscompares++;
      $display("FAIL sw_m2: got len %0d mem_idx %0d mem_cnt %0d want 7 6 1", tr.size(), first_hit(S_MEM), count_hit(S_MEM));
    end
  endtask

  // Reset raised while B sits in MEM_WR: MEM_w drops at once, RST next cycle
  task automatic test_reset_mid_store();
    obs_t o;
    bit   seen = 0;
    reset_and_wait(1);
    opcode = OP_SW;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      o = get_obs(1);
      if (o.state == ST_MEM_WR) seen = 1;
    end
    vectors++;
    if (!seen || o.mem_w !== 1'b1) begin
      miscompares++;
      $display("FAIL reach_mem_wr: got state %0d mem_w %b want %0d 1", o.state, o.mem_w, ST_MEM_WR);
    end
    reset = 1'b1;
    #1;
    o = get_obs(1);
    vectors++;
    if (o.mem_w !== 1'b0 || we_bits(o) !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_gates_mem_w: got mem_w %b we %b want 0 00000000", o.mem_w, we_bits(o));
    end
    @(posedge clk); #1;
    o = get_obs(1);
    vectors++;
    if (o.state !== ST_RST || o.mem_w !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_store_state: got state %0d mem_w %b want %0d 0", o.state, o.mem_w, ST_RST);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_rtype();
    test_overflow();
    test_branch_jump();
    test_load_store();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run want finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ctrl_unit_mc.md
Name: ctrl_unit_mc

Overview:
Parametrised multicycle control FSM for the CPU datapath. Sequences fetch/decode/execute/memory/writeback for R-type (add, sub, and, xor), addi, lw, sw, beq, bne and j. Memory latency and reset-pulse length are configurable. Adds FUNCT decoding, branch resolution from ALU flags and unknown-opcode recovery. Drives all datapath write enables and mux selects.

Parameters:
MEM_WAIT, 1, extra wait cycles per memory read (0..15); a read occupies MEM_WAIT+1 cycles
RST_CYCLES, 1, cycles rst_out stays high after reset (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
Of  in  1  ALU overflow
Ng  in  1  ALU negative
Zr  in  1  ALU zero
Eq  in  1  ALU A==B
Gt  in  1  ALU A>B
Lt  in  1  ALU A<B
OPCODE  in  6  instruction [31:26]
FUNCT  in  6  instruction [5:0]
PC_w  out  1  PC write
MEM_w  out  1  memory write
IR_w  out  1  instruction register write
RB_w  out  1  register bank write
AB_w  out  1  A/B register write
ALUOUT_w  out  1  ALUOut register write
MDR_w  out  1  memory data register write
ULA_C  out  3  ALU op: 000 passA, 001 add, 010 sub, 011 and, 110 xor, 111 compare
M_WREG  out  2  reg-dest select: 00 rt, 01 rd, 10 $ra(31)
M_WDATA  out  1  reg write data: 0 ALUOut, 1 MDR
M_IORD  out  1  memory address: 0 PC, 1 ALUOut
M_ULAA  out  1  ALU A: 0 PC, 1 regA
M_ULAB  out  2  ALU B: 00 regB, 01 const 4, 10 signext imm, 11 signext imm<<2
M_PC  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target
rst_out  out  1  datapath reset
state_dbg  out  5  current state encoding

Behaviour:
- All outputs are Moore (state-decoded) except PC_w in BRANCH; defaults 0 in every state unless listed.
- reset=1 at any edge, including mid-instruction: state <= RST, counter <= 0; all enables 0 that cycle; no memory/register write may leak.
- RST: rst_out=1 for RST_CYCLES cycles, then FETCH.
- FETCH: M_IORD=0, M_ULAA=0, M_ULAB=01, ULA_C=001. Wait counter counts 0..MEM_WAIT; on final cycle IR_w=1, PC_w=1, M_PC=00 -> DECODE. MEM_WAIT=0 -> single cycle.
- DECODE (1 cycle): AB_w=1, ALUOUT_w=1, M_ULAA=0, M_ULAB=11, ULA_C=001 (branch target). Next by OPCODE: 0x00 -> EXEC_R; 0x08 -> EXEC_I; 0x23/0x2B -> ADDR; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; other -> FETCH (instruction ignored as NOP).
- EXEC_R: M_ULAA=1, M_ULAB=00, ALUOUT_w=1; ULA_C from FUNCT 0x20->001, 0x22->010, 0x24->011, 0x26->110; other FUNCT -> FETCH, no writeback. -> WB_R.
- WB_R: RB_w=1, M_WREG=01, M_WDATA=0 -> FETCH.
- EXEC_I: M_ULAA=1, M_ULAB=10, ULA_C=001, ALUOUT_w=1 -> WB_I. WB_I: RB_w=1, M_WREG=00, M_WDATA=0 -> FETCH.
- ADDR: same ALU setup as EXEC_I; -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: M_IORD=1; MEM_WAIT+1 cycles, MDR_w=1 on final cycle -> MEM_WB. MEM_WB: RB_w=1, M_WREG=00, M_WDATA=1 -> FETCH.
- MEM_WR: M_IORD=1, MEM_w=1 for exactly 1 cycle -> FETCH.
- BRANCH: M_ULAA=1, M_ULAB=00, ULA_C=111, M_PC=01; PC_w = Eq (beq) or ~Eq (bne) -> FETCH.
- JUMP: M_PC=10, PC_w=1 -> FETCH.
- Cycle counts (M=MEM_WAIT): R/addi 4+M, lw 6+2M, sw 5+M, branch/jump 3+M.
- Without overflow support, Of ignored; writeback proceeds.
- Wait counter 4 bits, clears on every state entry.

Optional Feature:
CTRL_OVF_EXC_EN. Defined: adds output EPC_w (1 bit) and M_PC code 11 (exception vector). EXEC_R add/sub and EXEC_I with Of=1 -> OVF instead of writeback; OVF: EPC_w=1, PC_w=1, M_PC=11, RB_w=0 -> FETCH (1 cycle). Undefined: EPC_w absent, Of ignored, M_PC never 11.

Decomposition:
Package ctrl_pkg: state encoding constants, opcode/funct constants, ULA_C codes, mux-select codes. One sub-module natural: ctrl_wait_cnt (loadable 4-bit down/up counter with done flag) shared by RST, FETCH, MEM_RD.

Test Plan:
- reset held 3 cycles, RST_CYCLES=2 -> rst_out high 2 cycles after release, all write enables 0 throughout, then FETCH.
- MEM_WAIT=2, add (OPCODE 0, FUNCT 0x20) -> IR_w/PC_w on cycle 3, RB_w with M_WREG=01 on cycle 6, total 6 cycles.
- lw then sw, MEM_WAIT=0 -> lw MDR_w then RB_w/M_WDATA=1 (6 cycles); sw MEM_w high exactly 1 cycle with M_IORD=1 (5 cycles).
- beq Eq=1 -> PC_w=1, M_PC=01; bne Eq=1 -> PC_w=0; opcode 0x3F -> back to FETCH after DECODE, no writes.
- reset asserted during MEM_WR state -> MEM_w 0 that edge onward, state RST next cycle.
- CTRL_OVF_EXC_EN, addi with Of=1 -> EPC_w=1, M_PC=11, RB_w never asserted.
